instr_fetch_unit: RTL and testbench

//  Upstream fetch stage for the single-cycle core: owns the program counter, issues word

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/instr_fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int INSTR_W      = 32;
  localparam int INSTR_BYTES  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [INSTR_W-1:0]      instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head reads as zero when empty.
// Depth must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             empty_s;
  logic             full_s;
  logic             do_pop_s;
  logic             do_push_s;

  // Handshake qualification: a push into a full FIFO is allowed only alongside a pop.
  always_comb begin
    empty_s   = (count_r == '0);
    full_s    = (count_r == CW'(DEPTH));
    do_pop_s  = pop && !empty_s;
    do_push_s = push && (!full_s || do_pop_s);
  end

  // Pointer and occupancy registers; flush discards every entry.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are masked at the head while empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Head presentation.
  always_comb begin
    if (empty_s) begin
      head = '0;
    end else begin
      head = mem_r[rd_ptr_r];
    end
  end

  assign count = count_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word fetches, buffers {pc, instr}
// for the core, and drains stale in-flight responses after a redirect.
module instr_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr
);

  import fetch_pkg::*;

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int EW  = XLEN + INSTR_W;
  localparam logic [XLEN-1:0] OFF_MASK = XLEN'(INSTR_BYTES - 32'sd1);

  fetch_state_e    state_r;
  fetch_state_e    state_next_s;
  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] fetch_pc_next_s;
  logic [XLEN-1:0] redirect_aligned_s;
  logic [CW-1:0]   drop_cnt_r;
  logic [CW-1:0]   drop_cnt_next_s;
  logic [CW-1:0]   drop_calc_s;
  logic [CW-1:0]   out_count_s;
  logic [CW-1:0]   pcq_count_s;
  logic [CW1-1:0]  credit_used_s;
  logic [EW-1:0]   out_head_s;
  logic [EW-1:0]   out_push_data_s;
  logic [XLEN-1:0] pcq_head_s;
  logic            fetching_s;
  logic            out_valid_s;
  logic            out_pop_s;
  logic            req_valid_s;
  logic            req_fire_s;
  logic            resp_accept_s;
  logic            pcq_push_s;

  // Datapath control. The PC queue holds exactly the live (non-stale) in-flight fetches,
  // so its count is the outstanding count while fetching. A pop in the current cycle
  // frees a slot immediately, which is what sustains one instruction per cycle.
  always_comb begin
    fetching_s         = (state_r == FETCH);
    out_valid_s        = (out_count_s != '0);
    out_pop_s          = out_valid_s && if_ready;
    credit_used_s      = CW1'(pcq_count_s) + CW1'(out_count_s) - CW1'(out_pop_s);
    req_valid_s        = fetching_s && (credit_used_s < CW1'(FIFO_DEPTH));
    req_fire_s         = req_valid_s && imem_req_ready;
    resp_accept_s      = fetching_s && imem_resp_valid && !redirect_valid;
    pcq_push_s         = req_fire_s && !redirect_valid;
    redirect_aligned_s = redirect_pc & ~OFF_MASK;
    drop_calc_s        = pcq_count_s + CW'(req_fire_s) - CW'(imem_resp_valid);
    out_push_data_s    = {pcq_head_s, imem_resp_data};
  end

  // Next-state, next fetch PC and stale-response counter.
  always_comb begin
    state_next_s    = state_r;
    fetch_pc_next_s = fetch_pc_r;
    drop_cnt_next_s = drop_cnt_r;
    case (state_r)
      IDLE: begin
        state_next_s = FETCH;
        if (redirect_valid) begin
          fetch_pc_next_s = redirect_aligned_s;
        end else begin
          fetch_pc_next_s = fetch_pc_r;
        end
      end
      FETCH: begin
        if (redirect_valid) begin
          fetch_pc_next_s = redirect_aligned_s;
          drop_cnt_next_s = drop_calc_s;
          if (drop_calc_s != '0) begin
            state_next_s = DRAIN;
          end else begin
            state_next_s = FETCH;
          end
        end else if (req_fire_s) begin
          fetch_pc_next_s = fetch_pc_r + XLEN'(INSTR_BYTES);
        end else begin
          fetch_pc_next_s = fetch_pc_r;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          fetch_pc_next_s = redirect_aligned_s;
        end else begin
          fetch_pc_next_s = fetch_pc_r;
        end
        if (imem_resp_valid && (drop_cnt_r != '0)) begin
          drop_cnt_next_s = drop_cnt_r - 1'b1;
        end else begin
          drop_cnt_next_s = drop_cnt_r;
        end
        if (drop_cnt_next_s == '0) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: begin
        state_next_s    = IDLE;
        fetch_pc_next_s = RESET_PC;
        drop_cnt_next_s = '0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      fetch_pc_r <= RESET_PC;
      drop_cnt_r <= '0;
    end else begin
      state_r    <= state_next_s;
      fetch_pc_r <= fetch_pc_next_s;
      drop_cnt_r <= drop_cnt_next_s;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_outbuf (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (resp_accept_s),
    .push_data (out_push_data_s),
    .pop       (out_pop_s),
    .head      (out_head_s),
    .count     (out_count_s)
  );

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (XLEN)
  ) u_pcq (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (pcq_push_s),
    .push_data (fetch_pc_r),
    .pop       (resp_accept_s),
    .head      (pcq_head_s),
    .count     (pcq_count_s)
  );

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_r;
  assign if_valid       = out_valid_s;
  assign if_pc          = out_head_s[EW-1:INSTR_W];
  assign if_instr       = out_head_s[INSTR_W-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a cycle table for streaming/backpressure plus
// hand sequences for redirect, drain, alignment, PC wrap and mid-operation reset.
module tb_instr_fetch_unit;

  localparam int          XLEN   = 32;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] mq[$];
  logic        mem_hold;

  instr_fetch_unit #(
    .XLEN       (XLEN),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, then update the 1-cycle memory model.
  task automatic tick();
    logic        fire;
    logic [31:0] faddr;
    logic        consumed;
    fire     = imem_req_valid && imem_req_ready;
    faddr    = imem_req_addr;
    consumed = imem_resp_valid;
    if (consumed && !redirect_valid && (int'(dut.out_count_s) == DEPTH) && !(if_valid && if_ready)) begin
      n_bad++;
      $display("FAIL resp_into_full_fifo: got response with buffer full, required none");
    end
    @(posedge clk);
    #1;
    if (reset) begin
      mq.delete();
    end else begin
      if (consumed && (mq.size() > 0)) void'(mq.pop_front());
      if (fire) mq.push_back(faddr);
    end
    if (!reset && (mq.size() > 0) && !mem_hold) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_hold       = 1'b0;
    if_ready       = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_ifv(input int max_cyc);
    int n;
    n = 0;
    while (!if_valid && (n < max_cyc)) begin
      tick();
      n++;
    end
    if (!if_valid) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_if_valid: got 0 required 1 within %0d cycles", max_cyc);
    end
  endtask

  task automatic wait_req(input int max_cyc);
    int n;
    n = 0;
    while (!imem_req_valid && (n < max_cyc)) begin
      tick();
      n++;
    end
    if (!imem_req_valid) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_req_valid: got 0 required 1 within %0d cycles", max_cyc);
    end
  endtask

  typedef struct packed {
    logic        ifr;
    logic        exp_rqv;
    logic [31:0] exp_addr;
    logic        exp_ifv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        tbl [13];
  logic [31:0] wrap_exp [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    if_ready        = 1'b1;
    imem_req_ready  = 1'b1;
    mem_hold        = 1'b0;

    // Streaming from reset, then backpressure and release (cycle A = first out of reset).
    tbl[0]  = '{1'b1, 1'b0, 32'd0,  1'b0, 32'd0};
    tbl[1]  = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
    tbl[2]  = '{1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
    tbl[3]  = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
    tbl[4]  = '{1'b1, 1'b1, 32'd12, 1'b1, 32'd4};
    tbl[5]  = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd8};
    tbl[6]  = '{1'b0, 1'b0, 32'd20, 1'b1, 32'd12};
    tbl[7]  = '{1'b0, 1'b0, 32'd20, 1'b1, 32'd12};
    tbl[8]  = '{1'b0, 1'b0, 32'd20, 1'b1, 32'd12};
    tbl[9]  = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd12};
    tbl[10] = '{1'b1, 1'b1, 32'd24, 1'b1, 32'd16};
    tbl[11] = '{1'b1, 1'b1, 32'd28, 1'b1, 32'd20};
    tbl[12] = '{1'b1, 1'b1, 32'd32, 1'b1, 32'd24};

    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    wrap_exp[3] = 32'h0000_0004;

    // Reset state while reset is held.
    tick();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      if_ready = tbl[i].ifr;
      #1;
      chk($sformatf("v%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, tbl[i].exp_rqv});
      chk($sformatf("v%0d_req_addr", i), imem_req_addr, tbl[i].exp_addr);
      chk($sformatf("v%0d_if_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].exp_ifv});
      chk($sformatf("v%0d_if_pc", i), if_pc, tbl[i].exp_pc);
      chk($sformatf("v%0d_if_instr", i), if_instr, tbl[i].exp_ifv ? mem_word(tbl[i].exp_pc) : 32'd0);
      tick();
    end

    // Redirect with two fetches in flight, then a second redirect while draining.
    do_reset();
    mem_hold = 1'b1;
    tick();
    tick();
    tick();
    #1;
    chk("drn_credit_cap", {31'd0, imem_req_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_pc = 32'h0000_0180;
    #1;
    chk("drn_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("drn_if_valid", {31'd0, if_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    mem_hold       = 1'b0;
    wait_req(20);
    chk("drn_next_addr", imem_req_addr, 32'h0000_0180);
    wait_ifv(20);
    chk("drn_first_pc", if_pc, 32'h0000_0180);
    chk("drn_first_instr", if_instr, mem_word(32'h0000_0180));

    // Misaligned redirect in the same cycle as a response.
    do_reset();
    tick();
    tick();
    #1;
    chk("al_resp_present", {31'd0, imem_resp_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("al_resp_dropped", {31'd0, if_valid}, 32'd0);
    wait_req(20);
    chk("al_req_addr", imem_req_addr, 32'h0000_0200);
    wait_ifv(20);
    chk("al_first_pc", if_pc, 32'h0000_0200);

    // PC wrap past the top of the address space.
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    wait_ifv(20);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrap%0d_if_valid", k), {31'd0, if_valid}, 32'd1);
      chk($sformatf("wrap%0d_if_pc", k), if_pc, wrap_exp[k]);
      chk($sformatf("wrap%0d_instr", k), if_instr, mem_word(wrap_exp[k]));
      tick();
    end

    // Reset while draining: in-flight fetches forgotten.
    do_reset();
    mem_hold = 1'b1;
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("rd_in_drain", {31'd0, imem_req_valid}, 32'd0);
    reset = 1'b1;
    tick();
    #1;
    chk("rd_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rd_req_addr", imem_req_addr, RST_PC);
    chk("rd_req_valid", {31'd0, imem_req_valid}, 32'd0);
    reset    = 1'b0;
    mem_hold = 1'b0;
    #1;
    chk("rd_idle_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("rd_fetch_req", {31'd0, imem_req_valid}, 32'd1);
    chk("rd_fetch_addr", imem_req_addr, RST_PC);
    wait_ifv(20);
    chk("rd_first_pc", if_pc, RST_PC);
    chk("rd_first_instr", if_instr, mem_word(RST_PC));

    // Reset with the output buffer full.
    do_reset();
    if_ready = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("rf_full_valid", {31'd0, if_valid}, 32'd1);
    chk("rf_full_pc", if_pc, 32'd0);
    reset = 1'b1;
    tick();
    chk("rf_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rf_if_pc", if_pc, 32'd0);
    chk("rf_if_instr", if_instr, 32'd0);
    chk("rf_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rf_req_addr", imem_req_addr, RST_PC);
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
